// File: rtl/manual_pkg.sv
// Shared encodings for the manual-transmission drive controller.
package manual_pkg;

    localparam logic [1:0] ST_NSTART = 2'b00;
    localparam logic [1:0] ST_START  = 2'b01;
    localparam logic [1:0] ST_MOVING = 2'b10;

    localparam logic [3:0] MV_NONE    = 4'b0000;
    localparam logic [3:0] MV_FORWARD = 4'b0001;
    localparam logic [3:0] MV_BACK    = 4'b0010;
    localparam logic [3:0] MV_RIGHT   = 4'b0100;
    localparam logic [3:0] MV_LEFT    = 4'b1000;

    localparam logic POFF = 1'b0;
    localparam logic PON  = 1'b1;

    // Reverse gear overrides steering; conflicting left+right means straight ahead.
    function automatic logic [3:0] drive_dir(input logic rgs, input logic left, input logic right);
        if (rgs)
            return MV_BACK;
        if (left && !right)
            return MV_LEFT;
        if (right && !left)
            return MV_RIGHT;
        return MV_FORWARD;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Free-running millisecond prescaler: one-cycle tick every MS_DIV clocks.
module ms_tick_gen #(
    parameter int MS_DIV = 100_000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = $clog2(MS_DIV + 2);
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(MS_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == '0);

    always_comb begin
        cnt_d = cnt_q - CNT_W'(1);
        if (tick)
            cnt_d = RELOAD;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= RELOAD;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/manual_drive_ctrl.sv
// Drive controller: power sequencing, NSTART/START/MOVING FSM, turn lights,
// idle auto-power-off and saturating mileage.
//   state  | meaning
//   NSTART | powered, engine not started (hazard blink, idle timer runs)
//   START  | engine running, stationary
//   MOVING | vehicle in motion, direction in moving_state, mileage counts
module manual_drive_ctrl
    import manual_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int POWER_ON_MS = 1000,
    parameter int BLINK_MS    = 500,
    parameter int IDLE_MS     = 10000,
    parameter int MILE_MS     = 1000,
    parameter int MILEAGE_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 power_on,
    input  logic                 power_off,
    input  logic                 clutch,
    input  logic                 brake,
    input  logic                 throttle,
    input  logic                 rgs,
    input  logic                 left,
    input  logic                 right,
    output logic                 power,
    output logic [1:0]           state,
    output logic [3:0]           moving_state,
    output logic                 turn_left_light,
    output logic                 turn_right_light,
    output logic                 power_light,
    output logic [2:0]           state_light,
    output logic [3:0]           moving_light,
    output logic [MILEAGE_W-1:0] mileage
);

    localparam int MS_DIV = CLK_FREQ_HZ / 1000;
    localparam int PON_W  = $clog2(POWER_ON_MS + 2);
    localparam int BLK_W  = $clog2(BLINK_MS + 2);
    localparam int IDL_W  = $clog2(IDLE_MS + 2);
    localparam int MIL_W  = $clog2(MILE_MS + 2);
    localparam logic [PON_W-1:0] PON_TC = PON_W'(POWER_ON_MS - 1);
    localparam logic [BLK_W-1:0] BLK_TC = BLK_W'(BLINK_MS - 1);
    localparam logic [IDL_W-1:0] IDL_TC = IDL_W'((IDLE_MS > 0) ? IDLE_MS - 1 : 0);
    localparam logic [MIL_W-1:0] MIL_TC = MIL_W'(MILE_MS - 1);

    logic tick;

    ms_tick_gen #(.MS_DIV(MS_DIV)) u_ms_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    logic                 power_q, power_d;
    logic [1:0]           state_q, state_d;
    logic [3:0]           moving_q, moving_d;
    logic                 turn_l_q, turn_l_d;
    logic                 turn_r_q, turn_r_d;
    logic                 blink_q, blink_d;
    logic [MILEAGE_W-1:0] mileage_q, mileage_d;
    logic [PON_W-1:0]     pon_cnt_q, pon_cnt_d;
    logic [BLK_W-1:0]     blink_cnt_q, blink_cnt_d;
    logic [IDL_W-1:0]     idle_cnt_q, idle_cnt_d;
    logic [MIL_W-1:0]     mile_cnt_q, mile_cnt_d;
    logic                 any_in, idle_expire, stall;

    always_comb begin
        power_d     = power_q;
        state_d     = state_q;
        moving_d    = moving_q;
        blink_d     = blink_q;
        mileage_d   = mileage_q;
        pon_cnt_d   = pon_cnt_q;
        blink_cnt_d = blink_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        mile_cnt_d  = mile_cnt_q;
        idle_expire = 1'b0;
        stall       = 1'b0;
        any_in      = clutch | brake | throttle | rgs | left | right;

        if (tick) begin
            if (blink_cnt_q == BLK_TC) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLK_W'(1);
            end
        end

        if (!(power_q && state_q == ST_NSTART && !any_in) || IDLE_MS == 0) begin
            idle_cnt_d = '0;
        end else if (tick) begin
            if (idle_cnt_q == IDL_TC) begin
                idle_cnt_d  = '0;
                idle_expire = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + IDL_W'(1);
            end
        end

        if (state_q != ST_MOVING) begin
            mile_cnt_d = '0;
        end else if (tick) begin
            if (mile_cnt_q == MIL_TC) begin
                mile_cnt_d = '0;
                if (mileage_q != {MILEAGE_W{1'b1}})
                    mileage_d = mileage_q + MILEAGE_W'(1);
            end else begin
                mile_cnt_d = mile_cnt_q + MIL_W'(1);
            end
        end

        if (!power_q) begin
            if (!power_on) begin
                pon_cnt_d = '0;
            end else if (tick) begin
                if (pon_cnt_q == PON_TC) begin
                    pon_cnt_d = '0;
                    power_d   = PON;
                    state_d   = ST_NSTART;
                    moving_d  = MV_NONE;
                end else begin
                    pon_cnt_d = pon_cnt_q + PON_W'(1);
                end
            end
        end else begin
            case (state_q)
                ST_NSTART: begin
                    moving_d = MV_NONE;
                    if (brake)
                        state_d = ST_NSTART;
                    else if (throttle && !clutch)
                        stall = 1'b1;
                    else if (throttle && clutch && !rgs)
                        state_d = ST_START;
                end
                ST_START: begin
                    moving_d = MV_NONE;
                    if (brake) begin
                        state_d = ST_NSTART;
                    end else if (throttle && !clutch) begin
                        state_d  = ST_MOVING;
                        moving_d = drive_dir(rgs, left, right);
                    end
                end
                ST_MOVING: begin
                    if (rgs && !clutch) begin
                        stall = 1'b1;
                    end else if (brake) begin
                        state_d  = ST_NSTART;
                        moving_d = MV_NONE;
                    end else if (!throttle) begin
                        state_d  = ST_START;
                        moving_d = MV_NONE;
                    end else begin
                        moving_d = drive_dir(rgs, left, right);
                    end
                end
                default: begin
                    state_d  = ST_NSTART;
                    moving_d = MV_NONE;
                end
            endcase
            if (power_off || stall || idle_expire) begin
                power_d  = POFF;
                state_d  = ST_NSTART;
                moving_d = MV_NONE;
            end
        end

        // Lights follow the post-edge state so they change together with it.
        turn_l_d = power_d & blink_d & ((state_d == ST_NSTART) | left);
        turn_r_d = power_d & blink_d & ((state_d == ST_NSTART) | right);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            power_q     <= POFF;
            state_q     <= ST_NSTART;
            moving_q    <= MV_NONE;
            turn_l_q    <= 1'b0;
            turn_r_q    <= 1'b0;
            blink_q     <= 1'b1;
            mileage_q   <= '0;
            pon_cnt_q   <= '0;
            blink_cnt_q <= '0;
            idle_cnt_q  <= '0;
            mile_cnt_q  <= '0;
        end else begin
            power_q     <= power_d;
            state_q     <= state_d;
            moving_q    <= moving_d;
            turn_l_q    <= turn_l_d;
            turn_r_q    <= turn_r_d;
            blink_q     <= blink_d;
            mileage_q   <= mileage_d;
            pon_cnt_q   <= pon_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            idle_cnt_q  <= idle_cnt_d;
            mile_cnt_q  <= mile_cnt_d;
        end
    end

    always_comb begin
        state_light = 3'b000;
        if (power_q) begin
            case (state_q)
                ST_NSTART: state_light = 3'b001;
                ST_START:  state_light = 3'b010;
                ST_MOVING: state_light = 3'b100;
                default:   state_light = 3'b000;
            endcase
        end
    end

    assign power            = power_q;
    assign state            = state_q;
    assign moving_state     = moving_q;
    assign turn_left_light  = turn_l_q;
    assign turn_right_light = turn_r_q;
    assign power_light      = power_q;
    assign moving_light     = power_q ? moving_q : 4'b0000;
    assign mileage          = mileage_q;

endmodule
